// File: rtl/retire_pkg.sv
// Shared types and decode helpers for the retire stage.
package retire_pkg;

  typedef enum logic [3:0] {
    NOP, ADD, LB, LBU, LH, LHU, LW, SB, SH, SW, JAL, BEQ, MRET
  } iType_e;

  typedef enum logic [3:0] {
    EXC_INST_MISALIGNED  = 4'd0,
    EXC_ILLEGAL_INST     = 4'd2,
    EXC_LOAD_MISALIGNED  = 4'd4,
    EXC_STORE_MISALIGNED = 4'd6,
    EXC_ECALL_M          = 4'd11
  } exceptionCode_e;

  typedef enum logic {RUN, TRAP_WAIT} retireState_e;

  // Access size encodings shared by load and store decode
  localparam logic [1:0] LS_BYTE = 2'd0;
  localparam logic [1:0] LS_HALF = 2'd1;
  localparam logic [1:0] LS_WORD = 2'd2;

  function automatic logic is_load(iType_e op);
    return (op == LB) || (op == LBU) || (op == LH) || (op == LHU) || (op == LW);
  endfunction

  function automatic logic is_store(iType_e op);
    return (op == SB) || (op == SH) || (op == SW);
  endfunction

  function automatic logic [1:0] access_size(iType_e op);
    case (op)
      LB, LBU, SB: return LS_BYTE;
      LH, LHU, SH: return LS_HALF;
      default:     return LS_WORD;
    endcase
  endfunction

  // Only the signed loads replicate the top data bit
  function automatic logic load_signed(iType_e op);
    return (op == LB) || (op == LH);
  endfunction

  function automatic logic misaligned(logic [1:0] size, logic [1:0] addr);
    case (size)
      LS_HALF: return addr[0];
      LS_WORD: return |addr;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/retire_load_aligner.sv
// Selects the addressed byte/halfword of a load and extends it to 32 bits.
module load_aligner
  import retire_pkg::*;
(
  input  logic [1:0]  address,
  input  iType_e      operation,
  input  logic [31:0] mem_data,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sgn;

  // Lane select followed by sign/zero extension
  always_comb begin
    case (address)
      2'd0:    byte_sel = mem_data[7:0];
      2'd1:    byte_sel = mem_data[15:8];
      2'd2:    byte_sel = mem_data[23:16];
      default: byte_sel = mem_data[31:24];
    endcase
    half_sel = address[1] ? mem_data[31:16] : mem_data[15:0];
    sgn      = load_signed(operation);
    case (access_size(operation))
      LS_BYTE: data = {{24{sgn & byte_sel[7]}}, byte_sel};
      LS_HALF: data = {{16{sgn & half_sel[15]}}, half_sel};
      default: data = mem_data;
    endcase
  end

endmodule

// File: rtl/retire.sv
// Final pipeline stage: kills stale-tag instructions, writes back, issues
// stores, redirects on jumps/MRET and raises precise traps to the CSR bank.
module retire
  import retire_pkg::*;
#(
  parameter int TAG_W     = 3,
  parameter int INSTRET_W = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 stall,
  input  logic [31:0]          instruction_i,
  input  logic [31:0]          pc_i,
  input  iType_e               instruction_operation_i,
  input  logic [1:0][31:0]     result_i,
  input  logic [TAG_W-1:0]     tag_i,
  input  logic                 jump_i,
  input  logic                 write_enable_i,
  input  logic [3:0]           mem_write_enable_i,
  input  logic [31:0]          mem_data_i,
  input  logic                 exc_ilegal_inst_i,
  input  logic                 exc_misaligned_fetch_i,
  input  logic                 trap_ack_i,
  input  logic [31:0]          mtvec_i,
  input  logic [31:0]          mepc_i,
  output logic                 regbank_we_o,
  output logic [4:0]           regbank_addr_o,
  output logic [31:0]          regbank_data_o,
  output logic [3:0]           mem_write_enable_o,
  output logic [31:0]          mem_address_o,
  output logic [31:0]          mem_data_o,
  output logic                 jump_o,
  output logic [31:0]          jump_target_o,
  output logic [TAG_W-1:0]     current_tag_o,
  output logic                 trap_req_o,
  output exceptionCode_e       trap_cause_o,
  output logic [31:0]          trap_pc_o,
  output logic [31:0]          trap_value_o,
  output logic [INSTRET_W-1:0] instret_o
);

  retireState_e   state;
  logic           ack_seen;
  logic           valid, exc_raw, fire, retire_ok, trap_now, redirect;
  logic           mis_load, mis_store, mis_jump;
  exceptionCode_e exc_cause;
  logic [31:0]    exc_value, load_value, wb_data, redirect_target;
  logic [4:0]     rd;

  assign rd = instruction_i[11:7];

  load_aligner u_load_aligner (
    .address   (result_i[1][1:0]),
    .operation (instruction_operation_i),
    .mem_data  (mem_data_i),
    .data      (load_value)
  );

  // Validity, exception priority and same-cycle store drive
  always_comb begin
    valid     = (tag_i == current_tag_o) && (state == RUN) &&
                (instruction_operation_i != NOP);
    mis_load  = is_load(instruction_operation_i) &&
                misaligned(access_size(instruction_operation_i), result_i[1][1:0]);
    mis_store = is_store(instruction_operation_i) &&
                misaligned(access_size(instruction_operation_i), result_i[1][1:0]);
    mis_jump  = jump_i && (result_i[1][1:0] != 2'b00);

    exc_raw   = 1'b1;
    exc_cause = EXC_INST_MISALIGNED;
    exc_value = '0;
    if (exc_misaligned_fetch_i) begin
      exc_value = pc_i;
    end else if (exc_ilegal_inst_i) begin
      exc_cause = EXC_ILLEGAL_INST;
      exc_value = instruction_i;
    end else if (mis_load) begin
      exc_cause = EXC_LOAD_MISALIGNED;
      exc_value = result_i[1];
    end else if (mis_store) begin
      exc_cause = EXC_STORE_MISALIGNED;
      exc_value = result_i[1];
    end else if (mis_jump) begin
      exc_value = result_i[1];
    end else begin
      exc_raw = 1'b0;
    end

    fire      = valid && !stall;
    retire_ok = fire && !exc_raw;
    trap_now  = fire && exc_raw;
    redirect  = retire_ok && (jump_i || (instruction_operation_i == MRET));
    redirect_target = (instruction_operation_i == MRET) ? mepc_i : result_i[1];
    wb_data   = is_load(instruction_operation_i) ? load_value : result_i[0];

    mem_write_enable_o = retire_ok ? mem_write_enable_i : 4'b0000;
    mem_address_o      = (valid && !exc_raw) ? result_i[1] : 32'h0;
    mem_data_o         = (valid && !exc_raw) ? result_i[0] : 32'h0;
  end

  // Trap FSM plus all registered outputs (writeback, redirect, tag, instret)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= RUN;
      ack_seen       <= 1'b0;
      regbank_we_o   <= 1'b0;
      regbank_addr_o <= '0;
      regbank_data_o <= '0;
      jump_o         <= 1'b0;
      jump_target_o  <= '0;
      current_tag_o  <= '0;
      trap_req_o     <= 1'b0;
      trap_cause_o   <= EXC_INST_MISALIGNED;
      trap_pc_o      <= '0;
      trap_value_o   <= '0;
      instret_o      <= '0;
    end else if (stall) begin
      // Hold everything, but remember an acknowledge seen while held
      if (state == TRAP_WAIT && trap_ack_i) begin
        ack_seen <= 1'b1;
      end
    end else begin
      regbank_we_o <= 1'b0;
      jump_o       <= 1'b0;
      case (state)
        RUN: begin
          if (trap_now) begin
            state        <= TRAP_WAIT;
            ack_seen     <= 1'b0;
            trap_req_o   <= 1'b1;
            trap_cause_o <= exc_cause;
            trap_pc_o    <= pc_i;
            trap_value_o <= exc_value;
          end else if (retire_ok) begin
            instret_o <= instret_o + INSTRET_W'(1);
            if (write_enable_i && rd != 5'd0) begin
              regbank_we_o   <= 1'b1;
              regbank_addr_o <= rd;
              regbank_data_o <= wb_data;
            end
            if (redirect) begin
              jump_o        <= 1'b1;
              jump_target_o <= redirect_target;
              current_tag_o <= current_tag_o + TAG_W'(1);
            end
          end
        end
        TRAP_WAIT: begin
          if (trap_ack_i || ack_seen) begin
            state         <= RUN;
            ack_seen      <= 1'b0;
            trap_req_o    <= 1'b0;
            jump_o        <= 1'b1;
            jump_target_o <= mtvec_i;
            current_tag_o <= current_tag_o + TAG_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_retire.sv
// Directed bench for the retire stage: vector table plus trap/jump/reset sequences.
module tb_retire;
  import retire_pkg::*;

  logic             clk, reset_n, stall;
  logic [31:0]      instruction_i, pc_i;
  iType_e           instruction_operation_i;
  logic [1:0][31:0] result_i;
  logic [2:0]       tag_i;
  logic             jump_i, write_enable_i;
  logic [3:0]       mem_write_enable_i;
  logic [31:0]      mem_data_i;
  logic             exc_ilegal_inst_i, exc_misaligned_fetch_i, trap_ack_i;
  logic [31:0]      mtvec_i, mepc_i;
  logic             regbank_we_o;
  logic [4:0]       regbank_addr_o;
  logic [31:0]      regbank_data_o;
  logic [3:0]       mem_write_enable_o;
  logic [31:0]      mem_address_o, mem_data_o;
  logic             jump_o;
  logic [31:0]      jump_target_o;
  logic [2:0]       current_tag_o;
  logic             trap_req_o;
  exceptionCode_e   trap_cause_o;
  logic [31:0]      trap_pc_o, trap_value_o;
  logic [63:0]      instret_o;

  retire dut (
    .clk(clk), .reset_n(reset_n), .stall(stall),
    .instruction_i(instruction_i), .pc_i(pc_i),
    .instruction_operation_i(instruction_operation_i), .result_i(result_i),
    .tag_i(tag_i), .jump_i(jump_i), .write_enable_i(write_enable_i),
    .mem_write_enable_i(mem_write_enable_i), .mem_data_i(mem_data_i),
    .exc_ilegal_inst_i(exc_ilegal_inst_i), .exc_misaligned_fetch_i(exc_misaligned_fetch_i),
    .trap_ack_i(trap_ack_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
    .regbank_we_o(regbank_we_o), .regbank_addr_o(regbank_addr_o),
    .regbank_data_o(regbank_data_o), .mem_write_enable_o(mem_write_enable_o),
    .mem_address_o(mem_address_o), .mem_data_o(mem_data_o),
    .jump_o(jump_o), .jump_target_o(jump_target_o), .current_tag_o(current_tag_o),
    .trap_req_o(trap_req_o), .trap_cause_o(trap_cause_o), .trap_pc_o(trap_pc_o),
    .trap_value_o(trap_value_o), .instret_o(instret_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    iType_e      op;
    logic [4:0]  rd;
    logic [31:0] r0;
    logic [31:0] r1;
    logic [2:0]  tag;
    logic        we;
    logic [3:0]  lanes;
    logic [31:0] mdata;
    logic        exp_we;
    logic [31:0] exp_data;
    logic [3:0]  exp_lanes;
    logic        exp_inc;
  } vec_t;

  localparam int NV = 12;
  vec_t        vecs [NV];
  int          checks = 0;
  int          failures = 0;
  logic [63:0] exp_instret = 0;
  logic [2:0]  exp_tag = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    stall = 0; instruction_i = 0; pc_i = 0; instruction_operation_i = NOP;
    result_i = '0; tag_i = 0; jump_i = 0; write_enable_i = 0;
    mem_write_enable_i = 0; mem_data_i = 0; exc_ilegal_inst_i = 0;
    exc_misaligned_fetch_i = 0; trap_ack_i = 0; mtvec_i = 0; mepc_i = 0;
  endtask

  task automatic drive_op(input iType_e op, input logic [4:0] rd, input logic [31:0] r0,
                          input logic [31:0] r1, input logic [2:0] tag, input logic we);
    clear_in();
    instruction_operation_i = op;
    instruction_i = {20'h0, rd, 7'h33};
    result_i[0] = r0; result_i[1] = r1; tag_i = tag; write_enable_i = we;
  endtask

  task automatic ack_trap(input logic [31:0] vec);
    clear_in();
    trap_ack_i = 1; mtvec_i = vec;
    step();
    exp_tag = exp_tag + 3'd1;
    chk("ack_jump", jump_o, 1);
    chk("ack_target", jump_target_o, vec);
    chk("ack_tag", current_tag_o, exp_tag);
    chk("ack_req_drop", trap_req_o, 0);
    clear_in();
  endtask

  initial begin
    vecs[0]  = '{ADD, 5'd5,  32'h1234,     32'h0,    3'd0, 1'b1, 4'h0, 32'h0,        1'b1, 32'h1234,     4'h0, 1'b1};
    vecs[1]  = '{LB,  5'd6,  32'h0,        32'h103,  3'd0, 1'b1, 4'h0, 32'h80AABBCC, 1'b1, 32'hFFFFFF80, 4'h0, 1'b1};
    vecs[2]  = '{LHU, 5'd7,  32'h0,        32'h102,  3'd0, 1'b1, 4'h0, 32'h80AABBCC, 1'b1, 32'h000080AA, 4'h0, 1'b1};
    vecs[3]  = '{LH,  5'd8,  32'h0,        32'h102,  3'd0, 1'b1, 4'h0, 32'h80AABBCC, 1'b1, 32'hFFFF80AA, 4'h0, 1'b1};
    vecs[4]  = '{LBU, 5'd9,  32'h0,        32'h101,  3'd0, 1'b1, 4'h0, 32'h80AABBCC, 1'b1, 32'h000000BB, 4'h0, 1'b1};
    vecs[5]  = '{LW,  5'd10, 32'h0,        32'h100,  3'd0, 1'b1, 4'h0, 32'h80AABBCC, 1'b1, 32'h80AABBCC, 4'h0, 1'b1};
    vecs[6]  = '{ADD, 5'd0,  32'h55,       32'h0,    3'd0, 1'b1, 4'h0, 32'h0,        1'b0, 32'h0,        4'h0, 1'b1};
    vecs[7]  = '{ADD, 5'd3,  32'h77,       32'h0,    3'd0, 1'b0, 4'h0, 32'h0,        1'b0, 32'h0,        4'h0, 1'b1};
    vecs[8]  = '{SW,  5'd0,  32'hDEADBEEF, 32'h2000, 3'd0, 1'b0, 4'hF, 32'h0,        1'b0, 32'h0,        4'hF, 1'b1};
    vecs[9]  = '{ADD, 5'd11, 32'h99,       32'h2000, 3'd3, 1'b1, 4'hF, 32'h0,        1'b0, 32'h0,        4'h0, 1'b0};
    vecs[10] = '{NOP, 5'd4,  32'h88,       32'h2000, 3'd0, 1'b1, 4'hF, 32'h0,        1'b0, 32'h0,        4'h0, 1'b0};
    vecs[11] = '{SB,  5'd0,  32'h000000AB, 32'h2003, 3'd0, 1'b0, 4'h8, 32'h0,        1'b0, 32'h0,        4'h8, 1'b1};

    clear_in();
    reset_n = 0;
    step(); step();
    chk("rst_we", regbank_we_o, 0);
    chk("rst_jump", jump_o, 0);
    chk("rst_tag", current_tag_o, 0);
    chk("rst_req", trap_req_o, 0);
    chk("rst_instret", instret_o, 0);
    chk("rst_target", jump_target_o, 0);
    reset_n = 1;
    step();

    // Table-driven single-instruction vectors
    for (int i = 0; i < NV; i++) begin
      drive_op(vecs[i].op, vecs[i].rd, vecs[i].r0, vecs[i].r1, vecs[i].tag, vecs[i].we);
      mem_write_enable_i = vecs[i].lanes;
      mem_data_i = vecs[i].mdata;
      #1;
      chk("vec_lanes", mem_write_enable_o, vecs[i].exp_lanes);
      if (vecs[i].exp_lanes != 0) begin
        chk("vec_addr", mem_address_o, vecs[i].r1);
        chk("vec_sdata", mem_data_o, vecs[i].r0);
      end
      step();
      if (vecs[i].exp_inc) exp_instret = exp_instret + 1;
      chk("vec_we", regbank_we_o, vecs[i].exp_we);
      if (vecs[i].exp_we) begin
        chk("vec_rd", regbank_addr_o, vecs[i].rd);
        chk("vec_wdata", regbank_data_o, vecs[i].exp_data);
      end
      chk("vec_instret", instret_o, exp_instret);
    end

    // Taken jump then a stale-tag instruction
    drive_op(JAL, 5'd1, 32'h104, 32'h200, 3'd0, 1'b1);
    jump_i = 1;
    step();
    exp_tag = 1; exp_instret = exp_instret + 1;
    chk("jmp_pulse", jump_o, 1);
    chk("jmp_target", jump_target_o, 32'h200);
    chk("jmp_tag", current_tag_o, exp_tag);
    chk("jmp_link_we", regbank_we_o, 1);
    drive_op(ADD, 5'd5, 32'h4321, 32'h0, 3'd0, 1'b1);
    step();
    chk("jmp_pulse_end", jump_o, 0);
    chk("stale_we", regbank_we_o, 0);
    chk("stale_instret", instret_o, exp_instret);

    // Illegal instruction trap, held three cycles, then acknowledged
    drive_op(ADD, 5'd31, 32'h1, 32'h0, exp_tag, 1'b1);
    instruction_i = 32'hFFFFFFFF; pc_i = 32'h40; exc_ilegal_inst_i = 1;
    step();
    chk("ill_req", trap_req_o, 1);
    chk("ill_cause", trap_cause_o, EXC_ILLEGAL_INST);
    chk("ill_pc", trap_pc_o, 32'h40);
    chk("ill_value", trap_value_o, 32'hFFFFFFFF);
    chk("ill_we", regbank_we_o, 0);
    chk("ill_instret", instret_o, exp_instret);
    for (int i = 0; i < 3; i++) begin
      drive_op(ADD, 5'd2, 32'h5, 32'h0, exp_tag, 1'b1);
      pc_i = 32'h44;
      step();
      chk("wait_req", trap_req_o, 1);
      chk("wait_pc", trap_pc_o, 32'h40);
      chk("wait_kill_we", regbank_we_o, 0);
      chk("wait_instret", instret_o, exp_instret);
    end
    ack_trap(32'h100);

    // Misaligned store: no strobes, cause 6
    drive_op(SW, 5'd0, 32'h11223344, 32'h1002, exp_tag, 1'b0);
    mem_write_enable_i = 4'hF; pc_i = 32'h50;
    #1;
    chk("sw_mis_lanes", mem_write_enable_o, 0);
    step();
    chk("sw_mis_req", trap_req_o, 1);
    chk("sw_mis_cause", trap_cause_o, EXC_STORE_MISALIGNED);
    chk("sw_mis_value", trap_value_o, 32'h1002);
    ack_trap(32'h100);

    // Misaligned fetch outranks illegal instruction
    drive_op(ADD, 5'd3, 32'h0, 32'h0, exp_tag, 1'b1);
    pc_i = 32'h46; exc_misaligned_fetch_i = 1; exc_ilegal_inst_i = 1;
    step();
    chk("prio_cause", trap_cause_o, EXC_INST_MISALIGNED);
    chk("prio_value", trap_value_o, 32'h46);
    ack_trap(32'h180);

    // MRET redirects to mepc
    drive_op(MRET, 5'd0, 32'h0, 32'h0, exp_tag, 1'b0);
    mepc_i = 32'h300;
    step();
    exp_tag = exp_tag + 3'd1; exp_instret = exp_instret + 1;
    chk("mret_jump", jump_o, 1);
    chk("mret_target", jump_target_o, 32'h300);
    chk("mret_tag", current_tag_o, exp_tag);
    chk("mret_instret", instret_o, exp_instret);

    // Stall blocks the store strobe and retirement
    drive_op(SW, 5'd0, 32'hCAFEF00D, 32'h3000, exp_tag, 1'b0);
    mem_write_enable_i = 4'hF; stall = 1;
    #1;
    chk("stall_lanes", mem_write_enable_o, 0);
    step();
    chk("stall_instret", instret_o, exp_instret);
    stall = 0;
    #1;
    chk("unstall_lanes", mem_write_enable_o, 4'hF);
    step();
    exp_instret = exp_instret + 1;
    chk("unstall_instret", instret_o, exp_instret);

    // Misaligned jump target traps; acknowledge arrives while stalled
    drive_op(JAL, 5'd1, 32'h0, 32'h202, exp_tag, 1'b1);
    jump_i = 1; pc_i = 32'h60;
    step();
    chk("mj_req", trap_req_o, 1);
    chk("mj_cause", trap_cause_o, EXC_INST_MISALIGNED);
    chk("mj_value", trap_value_o, 32'h202);
    chk("mj_we", regbank_we_o, 0);
    clear_in();
    stall = 1; trap_ack_i = 1; mtvec_i = 32'h140;
    step();
    chk("stall_ack_req", trap_req_o, 1);
    stall = 0; trap_ack_i = 0;
    step();
    exp_tag = exp_tag + 3'd1;
    chk("late_ack_req", trap_req_o, 0);
    chk("late_ack_jump", jump_o, 1);
    chk("late_ack_target", jump_target_o, 32'h140);
    chk("late_ack_tag", current_tag_o, exp_tag);

    // Eight taken jumps walk the tag through its wrap
    for (int i = 0; i < 8; i++) begin
      drive_op(BEQ, 5'd0, 32'h0, 32'h400 + 32'(4 * i), exp_tag, 1'b0);
      jump_i = 1;
      step();
      exp_tag = exp_tag + 3'd1; exp_instret = exp_instret + 1;
      chk("wrap_tag", current_tag_o, exp_tag);
      chk("wrap_target", jump_target_o, 32'h400 + 32'(4 * i));
    end
    chk("wrap_instret", instret_o, exp_instret);

    // Misaligned load trap, then reset while waiting for acknowledge
    drive_op(LH, 5'd4, 32'h0, 32'h101, exp_tag, 1'b1);
    pc_i = 32'h70;
    step();
    chk("ml_req", trap_req_o, 1);
    chk("ml_cause", trap_cause_o, EXC_LOAD_MISALIGNED);
    chk("ml_value", trap_value_o, 32'h101);
    clear_in();
    reset_n = 0;
    #1;
    chk("mid_rst_req", trap_req_o, 0);
    chk("mid_rst_tag", current_tag_o, 0);
    chk("mid_rst_instret", instret_o, 0);
    chk("mid_rst_cause", trap_cause_o, 0);
    step();
    reset_n = 1;
    step();
    drive_op(ADD, 5'd5, 32'hABCD, 32'h0, 3'd0, 1'b1);
    step();
    chk("post_rst_we", regbank_we_o, 1);
    chk("post_rst_data", regbank_data_o, 32'hABCD);
    chk("post_rst_instret", instret_o, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
